// File: rtl/nmos_dma_pkg.sv
// Shared owner codes, fixed-slot map boundaries and the decoded-slot struct for the DMA slot arbiter.
// Purely declarative: no latency and no flow control of its own.
package nmos_dma_pkg;

  localparam int LINE_LEN_DEF = 227;
  localparam int HPOS_W_DEF   = 9;

  typedef enum logic [3:0] {
    OWN_IDLE = 4'd0,
    OWN_REF  = 4'd1,
    OWN_DSK  = 4'd2,
    OWN_AUD  = 4'd3,
    OWN_SPR  = 4'd4,
    OWN_BPL  = 4'd5,
    OWN_COP  = 4'd6,
    OWN_BLT  = 4'd7,
    OWN_CPU  = 4'd8
  } owner_t;

  typedef enum logic [2:0] {
    FIX_NONE,
    FIX_REF,
    FIX_DSK,
    FIX_AUD,
    FIX_SPR
  } fix_t;

  // All fixed slots are odd and below 64, so the low six bits of HPOS are enough.
  localparam logic [5:0] REF_FIRST = 6'h01;
  localparam logic [5:0] DSK_FIRST = 6'h09;
  localparam logic [5:0] AUD_FIRST = 6'h0F;
  localparam logic [5:0] SPR_FIRST = 6'h17;
  localparam logic [5:0] SPR_LAST  = 6'h35;

  typedef struct packed {
    fix_t       cls;
    logic [2:0] idx;
  } slot_dec_t;

endpackage

// File: rtl/nmos_dma_slot_decode.sv
// Maps a slot number to its fixed-slot class and audio/sprite channel; purely combinational.
// No state, so it never stalls; the caller samples it on the CCK strobe edge.
module nmos_dma_slot_decode
  import nmos_dma_pkg::*;
#(
  parameter int HPOS_W = HPOS_W_DEF
) (
  input  logic [HPOS_W-1:0] nh,
  output slot_dec_t         dec
);

  logic [5:0] lo;
  logic       low_region;

  assign lo         = nh[5:0];
  assign low_region = ((nh >> 6) == '0) && lo[0];

  always_comb begin
    dec.cls = FIX_NONE;
    dec.idx = 3'd0;
    if (low_region) begin
      if (lo >= REF_FIRST && lo < DSK_FIRST) begin
        dec.cls = FIX_REF;
      end else if (lo >= DSK_FIRST && lo < AUD_FIRST) begin
        dec.cls = FIX_DSK;
      end else if (lo >= AUD_FIRST && lo < SPR_FIRST) begin
        dec.cls = FIX_AUD;
        dec.idx = 3'((lo - AUD_FIRST) >> 1);
      end else if (lo >= SPR_FIRST && lo <= SPR_LAST) begin
        // Each sprite owns two consecutive odd slots.
        dec.cls = FIX_SPR;
        dec.idx = 3'((lo - SPR_FIRST) >> 2);
      end
    end
  end

endmodule

// File: rtl/nmos_dma_slot_arbiter.sv
// Chip-bus DMA slot scheduler: one grant per CCK strobe, latency one strobe edge, requests held as levels until granted.
// Optional long-line (NTSC 227/228 alternation) support is enabled by defining DMA_ARB_LOL_EN.
module nmos_dma_slot_arbiter
  import nmos_dma_pkg::*;
#(
  parameter int LINE_LEN = LINE_LEN_DEF,
  parameter int HPOS_W   = HPOS_W_DEF
) (
  input  logic              C28M,
  input  logic              RESET_n,
  input  logic              CCK_STB,
  input  logic              NTSC,
  input  logic              DSK_REQ,
  input  logic [3:0]        AUD_REQ,
  input  logic [7:0]        SPR_REQ,
  input  logic              BPL_REQ,
  input  logic              COP_REQ,
  input  logic              BLT_REQ,
  input  logic              CPU_REQ,
  input  logic              BLTPRI,
  output logic [HPOS_W-1:0] HPOS,
  output logic [3:0]        SLOT_OWN,
  output logic [2:0]        SLOT_IDX,
  output logic              SLOT_STB,
  output logic              LINE_STB,
  output logic              LOL
);

  localparam logic [HPOS_W-1:0] LAST_SHORT = HPOS_W'(LINE_LEN - 1);

  logic [HPOS_W-1:0] last;
  logic [HPOS_W-1:0] nh;
  slot_dec_t         dec;
  owner_t            own_q;
  owner_t            own_d;
  logic [2:0]        idx_d;
  logic [1:0]        cpu_wait;
  logic [1:0]        cpu_wait_d;
  logic              yield;

`ifdef DMA_ARB_LOL_EN
  logic lol_q;

  assign last = lol_q ? HPOS_W'(LINE_LEN) : LAST_SHORT;
  assign LOL  = lol_q;

  always_ff @(posedge C28M or negedge RESET_n) begin
    if (!RESET_n) begin
      lol_q <= 1'b0;
    end else if (CCK_STB && nh == '0) begin
      lol_q <= NTSC ? !lol_q : 1'b0;
    end
  end
`else
  logic unused_ntsc;

  assign unused_ntsc = NTSC;
  assign last        = LAST_SHORT;
  assign LOL         = 1'b0;
`endif

  assign nh       = (HPOS == last) ? '0 : HPOS + 1'b1;
  assign SLOT_OWN = own_q;

  nmos_dma_slot_decode #(.HPOS_W(HPOS_W)) u_decode (
    .nh  (nh),
    .dec (dec)
  );

  // A CPU starved for three slots pushes a non-nasty blitter aside once.
  assign yield = !BLTPRI && CPU_REQ && (cpu_wait == 2'd3);

  always_comb begin
    own_d = OWN_IDLE;
    idx_d = 3'd0;
    if (dec.cls == FIX_REF) begin
      own_d = OWN_REF;
    end else if (dec.cls == FIX_DSK && DSK_REQ) begin
      own_d = OWN_DSK;
    end else if (dec.cls == FIX_AUD && AUD_REQ[dec.idx[1:0]]) begin
      own_d = OWN_AUD;
      idx_d = dec.idx;
    end else if (dec.cls == FIX_SPR && SPR_REQ[dec.idx]) begin
      own_d = OWN_SPR;
      idx_d = dec.idx;
    end else if (BPL_REQ) begin
      own_d = OWN_BPL;
    end else if (!nh[0] && COP_REQ) begin
      own_d = OWN_COP;
    end else if (BLT_REQ && !yield) begin
      own_d = OWN_BLT;
    end else if (CPU_REQ) begin
      own_d = OWN_CPU;
    end
  end

  always_comb begin
    cpu_wait_d = cpu_wait;
    if (!CPU_REQ || own_d == OWN_CPU) begin
      cpu_wait_d = 2'd0;
    end else if (cpu_wait != 2'd3) begin
      cpu_wait_d = cpu_wait + 2'd1;
    end
  end

  always_ff @(posedge C28M or negedge RESET_n) begin
    if (!RESET_n) begin
      HPOS     <= '0;
      own_q    <= OWN_IDLE;
      SLOT_IDX <= 3'd0;
      SLOT_STB <= 1'b0;
      LINE_STB <= 1'b0;
      cpu_wait <= 2'd0;
    end else begin
      SLOT_STB <= CCK_STB;
      LINE_STB <= CCK_STB && (nh == '0);
      if (CCK_STB) begin
        HPOS     <= nh;
        own_q    <= own_d;
        SLOT_IDX <= idx_d;
        cpu_wait <= cpu_wait_d;
      end
    end
  end

endmodule
